// File: rtl/exti_irq_dispatcher.sv
// exti_irq_dispatcher
//   Consumer side of the EXTI pending-request interface. Pulses or levels from
//   the EXTI controller (i_exti_pr) and software triggers (i_swier) set sticky
//   pending bits. Software clears bits with a write-1-to-clear strobe. The
//   lowest-index pending line is offered to the CPU core through a
//   request / acknowledge / end-of-interrupt handshake.
//
// Ports
//   i_clk        clock, all state on the rising edge
//   i_rst        asynchronous, active-high reset
//   i_exti_pr    per-line pending requests from the EXTI controller
//   i_swier      per-line software trigger, OR'd with i_exti_pr
//   i_pr_clr_we  write strobe for the pending clear register
//   i_pr_clr     W1C data; bit k = 1 clears pending[k] when i_pr_clr_we = 1
//   o_irq_req    request to the CPU core (REQ state)
//   o_irq_id     index of the requested or active line
//   i_irq_ack    CPU accepts the request; only honoured while o_irq_req = 1
//   i_irq_eoi    CPU end of interrupt; only honoured while o_active = 1
//   o_pending    sticky pending register
//   o_active     high while a line is in service
//   o_state      debug view of the FSM state (0 IDLE, 1 REQ, 2 ACTIVE)
//
// Handshake: o_irq_req stays high with o_irq_id stable until the cycle in which
// i_irq_ack is sampled high at a rising edge (the transfer happens on that edge),
// or until the requested line's pending bit is cleared by software, in which
// case the request is withdrawn. o_active then stays high until i_irq_eoi is
// sampled high. Every new request is preceded by at least one IDLE cycle.
module exti_irq_dispatcher #(
  parameter int NUM_LINES = 21,
  parameter int ID_W      = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_LINES-1:0] i_exti_pr,
  input  logic [NUM_LINES-1:0] i_swier,
  input  logic                 i_pr_clr_we,
  input  logic [NUM_LINES-1:0] i_pr_clr,
  output logic                 o_irq_req,
  output logic [ID_W-1:0]      o_irq_id,
  input  logic                 i_irq_ack,
  input  logic                 i_irq_eoi,
  output logic [NUM_LINES-1:0] o_pending,
  output logic                 o_active,
  output logic [1:0]           o_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_LINES-1:0] r_pending;
  logic [NUM_LINES-1:0] w_pending_nxt;
  logic [NUM_LINES-1:0] w_id_mask;
  logic [NUM_LINES-1:0] w_ack_clr;
  logic [NUM_LINES-1:0] w_set;
  logic [NUM_LINES-1:0] w_clr;
  logic [ID_W-1:0]      r_irq_id;
  logic [ID_W-1:0]      w_irq_id_nxt;
  logic [ID_W-1:0]      w_win_id;
  logic                 w_any;
  logic                 r_irq_req;
  logic                 r_active;

  // One-hot decode of the held id; avoids indexing the pending vector with an
  // id whose range is wider than the number of lines.
  always_comb begin
    w_id_mask = '0;
    for (int k = 0; k < NUM_LINES; k++) begin
      w_id_mask[k] = (r_irq_id == ID_W'(k));
    end
  end

  // Set beats clear on the same bit so an incoming edge is never lost.
  always_comb begin
    w_ack_clr     = ((r_state == ST_REQ) && i_irq_ack) ? w_id_mask : '0;
    w_set         = i_exti_pr | i_swier;
    w_clr         = ({NUM_LINES{i_pr_clr_we}} & i_pr_clr) | w_ack_clr;
    w_pending_nxt = w_set | (r_pending & ~w_clr);
  end

  // Fixed priority: scanning downward leaves the lowest set index as winner.
  always_comb begin
    w_win_id = '0;
    for (int k = NUM_LINES - 1; k >= 0; k--) begin
      if (r_pending[k]) w_win_id = ID_W'(k);
    end
    w_any = |r_pending;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_irq_id_nxt = r_irq_id;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_irq_id_nxt = w_win_id;
          w_state_nxt  = ST_REQ;
        end
      end
      ST_REQ: begin
        // Ack has priority over a software withdrawal in the same cycle. The
        // withdrawal looks at next-cycle pending so a clear that collides with
        // a fresh set of the same line keeps the request alive.
        if (i_irq_ack) begin
          w_state_nxt = ST_ACTIVE;
        end else if (~|(w_pending_nxt & w_id_mask)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (i_irq_eoi) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_irq_id  <= '0;
      r_irq_req <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_irq_id  <= w_irq_id_nxt;
      r_irq_req <= (w_state_nxt == ST_REQ);
      r_active  <= (w_state_nxt == ST_ACTIVE);
    end
  end

  assign o_irq_req = r_irq_req;
  assign o_irq_id  = r_irq_id;
  assign o_pending = r_pending;
  assign o_active  = r_active;
  assign o_state   = r_state;

endmodule

// File: tb/tb_exti_irq_dispatcher.sv
module tb_exti_irq_dispatcher;

  localparam int NL = 21;
  localparam int IW = 5;

  // clock / reset
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NL-1:0] exti_pr = '0;
  logic [NL-1:0] swier = '0;
  logic          pr_clr_we = 1'b0;
  logic [NL-1:0] pr_clr = '0;
  logic          irq_ack = 1'b0;
  logic          irq_eoi = 1'b0;
  logic          irq_req;
  logic [IW-1:0] irq_id;
  logic [NL-1:0] pending;
  logic          active;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exti_irq_dispatcher #(.NUM_LINES(NL), .ID_W(IW)) dut (
    .i_clk(clk), .i_rst(rst), .i_exti_pr(exti_pr), .i_swier(swier),
    .i_pr_clr_we(pr_clr_we), .i_pr_clr(pr_clr), .o_irq_req(irq_req),
    .o_irq_id(irq_id), .i_irq_ack(irq_ack), .i_irq_eoi(irq_eoi),
    .o_pending(pending), .o_active(active), .o_state(dbg_state)
  );

  // Reference model: service phase (0 idle, 1 requesting, 2 in service),
  // the line being offered/served, and the sticky pending set.
  int            m_phase;
  int            m_line;
  logic [NL-1:0] m_pend;

  task automatic model_reset();
    m_phase = 0;
    m_line  = 0;
    m_pend  = '0;
  endtask

  task automatic model_step();
    logic [NL-1:0] setv, clrv, nxt;
    int lowest;
    setv = exti_pr | swier;
    clrv = pr_clr_we ? pr_clr : '0;
    if (m_phase == 1 && irq_ack) clrv[m_line] = 1'b1;
    nxt = setv | (m_pend & ~clrv);
    if (m_phase == 0) begin
      if (m_pend != 0) begin
        lowest = 0;
        while (!m_pend[lowest]) lowest++;
        m_line  = lowest;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (irq_ack) m_phase = 2;
      else if (!nxt[m_line]) m_phase = 0;
    end else begin
      if (irq_eoi) m_phase = 0;
    end
    m_pend = nxt;
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic quiet();
    exti_pr = '0; swier = '0; pr_clr_we = 1'b0; pr_clr = '0;
    irq_ack = 1'b0; irq_eoi = 1'b0;
  endtask

  task automatic raise_and_wait_req(input int line);
    exti_pr = NL'(1) << line;
    tick();
    exti_pr = '0;
    tick();
  endtask

  task automatic ack_and_eoi();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b1;
    model_reset();
    tick(); tick();
    checks++;
    if (irq_req !== 1'b0 || irq_id !== '0 || pending !== '0 || active !== 1'b0) begin
      errors++;
      $display("FAIL reset: req=%b id=%0d pend=%h act=%b, want all 0", irq_req, irq_id, pending, active);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (irq_req !== 1'b0 || pending !== '0) begin
      errors++;
      $display("FAIL reset_release: req=%b pend=%h, want 0/0", irq_req, pending);
    end
  endtask

  task automatic test_basic();
    exti_pr = NL'(1) << 3;
    tick();
    exti_pr = '0;
    checks++;
    if (pending !== 21'h8 || irq_req !== 1'b0) begin
      errors++;
      $display("FAIL basic_t1: pend=%h req=%b, want 000008/0", pending, irq_req);
    end
    tick();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 5'd3) begin
      errors++;
      $display("FAIL basic_t2: req=%b id=%0d, want 1/3", irq_req, irq_id);
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++;
    if (pending !== '0 || active !== 1'b1 || irq_req !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack: pend=%h act=%b req=%b, want 0/1/0", pending, active, irq_req);
    end
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    checks++;
    if (active !== 1'b0 || irq_req !== 1'b0) begin
      errors++;
      $display("FAIL basic_eoi: act=%b req=%b, want 0/0", active, irq_req);
    end
  endtask

  task automatic test_priority();
    exti_pr = (NL'(1) << 7) | (NL'(1) << 2);
    tick(); exti_pr = '0; tick();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 5'd2) begin
      errors++;
      $display("FAIL prio_first: req=%b id=%0d, want 1/2", irq_req, irq_id);
    end
    ack_and_eoi();
    checks++;
    if (irq_req !== 1'b0 || pending !== 21'h80) begin
      errors++;
      $display("FAIL prio_idle_gap: req=%b pend=%h, want 0/000080", irq_req, pending);
    end
    tick();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 5'd7) begin
      errors++;
      $display("FAIL prio_second: req=%b id=%0d, want 1/7", irq_req, irq_id);
    end
    ack_and_eoi();
  endtask

  task automatic test_no_preempt();
    raise_and_wait_req(9);
    exti_pr = NL'(1); tick(); exti_pr = '0; tick();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 5'd9 || pending !== 21'h201) begin
      errors++;
      $display("FAIL no_preempt: req=%b id=%0d pend=%h, want 1/9/000201", irq_req, irq_id, pending);
    end
    ack_and_eoi();
    tick();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 5'd0) begin
      errors++;
      $display("FAIL no_preempt_next: req=%b id=%0d, want 1/0", irq_req, irq_id);
    end
    ack_and_eoi();
  endtask

  task automatic test_withdraw();
    raise_and_wait_req(5);
    pr_clr_we = 1'b1; pr_clr = NL'(1) << 5;
    tick();
    pr_clr_we = 1'b0; pr_clr = '0;
    checks++;
    if (irq_req !== 1'b0 || pending !== '0 || active !== 1'b0) begin
      errors++;
      $display("FAIL withdraw: req=%b pend=%h act=%b, want 0/0/0", irq_req, pending, active);
    end
    tick();
    raise_and_wait_req(5);
    pr_clr_we = 1'b1; pr_clr = NL'(1) << 5; exti_pr = NL'(1) << 5;
    tick();
    quiet();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 5'd5 || pending !== 21'h20) begin
      errors++;
      $display("FAIL withdraw_reset: req=%b id=%0d pend=%h, want 1/5/000020", irq_req, irq_id, pending);
    end
    ack_and_eoi();
  endtask

  task automatic test_ack_collide();
    raise_and_wait_req(4);
    irq_ack = 1'b1; exti_pr = NL'(1) << 4;
    tick();
    quiet();
    checks++;
    if (active !== 1'b1 || pending !== 21'h10) begin
      errors++;
      $display("FAIL ack_collide: act=%b pend=%h, want 1/000010", active, pending);
    end
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    tick();
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 5'd4 || active !== 1'b0) begin
      errors++;
      $display("FAIL stray_eoi: req=%b id=%0d act=%b, want 1/4/0", irq_req, irq_id, active);
    end
    ack_and_eoi();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++;
    if (irq_req !== 1'b0 || active !== 1'b0 || pending !== '0) begin
      errors++;
      $display("FAIL stray_ack: req=%b act=%b pend=%h, want 0/0/0", irq_req, active, pending);
    end
  endtask

  task automatic test_reset_mid();
    exti_pr = 21'h10_0001; tick(); exti_pr = '0; tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    exti_pr = NL'(1); tick(); exti_pr = '0;
    checks++;
    if (active !== 1'b1 || pending !== 21'h10_0001) begin
      errors++;
      $display("FAIL pre_reset: act=%b pend=%h, want 1/100001", active, pending);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (irq_req !== 1'b0 || irq_id !== '0 || pending !== '0 || active !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: req=%b id=%0d pend=%h act=%b, want all 0", irq_req, irq_id, pending, active);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (irq_req !== 1'b0 || pending !== '0 || active !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: req=%b pend=%h act=%b, want 0/0/0", irq_req, pending, active);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      exti_pr   = ($urandom_range(0, 3) == 0) ? (NL'(1) << $urandom_range(0, NL - 1)) : '0;
      swier     = ($urandom_range(0, 9) == 0) ? (NL'(1) << $urandom_range(0, NL - 1)) : '0;
      pr_clr_we = ($urandom_range(0, 5) == 0);
      pr_clr    = NL'($urandom) & NL'($urandom);
      irq_ack   = ($urandom_range(0, 2) == 0);
      irq_eoi   = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (pending !== m_pend) begin
        errors++;
        $display("FAIL rnd_pending c=%0d: got %h want %h", c, pending, m_pend);
      end
      checks++;
      if (irq_req !== (m_phase == 1)) begin
        errors++;
        $display("FAIL rnd_req c=%0d: got %b want %b", c, irq_req, (m_phase == 1));
      end
      checks++;
      if (active !== (m_phase == 2)) begin
        errors++;
        $display("FAIL rnd_active c=%0d: got %b want %b", c, active, (m_phase == 2));
      end
      if (m_phase != 0) begin
        checks++;
        if (irq_id !== IW'(m_line)) begin
          errors++;
          $display("FAIL rnd_id c=%0d: got %0d want %0d", c, irq_id, m_line);
        end
      end
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_no_preempt();
    test_withdraw();
    test_ack_collide();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
